// File: rtl/dac_serial_tx_if.sv
// Sample handshake plus DAC serial pins for dac_serial_tx.
// The master supplies samples and the slave transmits them.
interface dac_serial_tx_if;
    logic [11:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        sclk;
    logic        sync_n;
    logic        sdata;
    logic        done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sclk,
        input  sync_n,
        input  sdata,
        input  done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sclk,
        output sync_n,
        output sdata,
        output done
    );
endinterface

// File: rtl/dac_serial_tx.sv
// Frames 12-bit samples into 16-bit words and shifts them out MSB first to a
// DAC121S101-class converter, generating sclk/sync_n locally.
module dac_serial_tx #(
    parameter int unsigned HALF_PERIOD = 66,
    parameter logic [1:0]  PD_MODE     = 2'b00
) (
    input  logic           clk,
    input  logic           rst,
    dac_serial_tx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    localparam logic [7:0] PHASE_LAST = 8'(HALF_PERIOD - 1);

    state_t      r_state,    r_state_next;
    logic [7:0]  r_phase,    r_phase_next;
    logic [3:0]  r_bit_idx,  r_bit_idx_next;
    logic [14:0] r_shift,    r_shift_next;
    logic        r_gap_half, r_gap_half_next;
    logic        r_sclk,     r_sclk_next;
    logic        r_sync_n,   r_sync_n_next;
    logic        r_sdata,    r_sdata_next;
    logic        r_din_ready, r_din_ready_next;
    logic        r_done,     r_done_next;

    logic [15:0] w_frame;
    logic        w_accept;
    logic        w_phase_end;

    assign w_frame     = {2'b00, PD_MODE, bus.din};
    assign w_accept    = bus.din_valid && r_din_ready;
    assign w_phase_end = (r_phase == PHASE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_phase     <= 8'd0;
            r_bit_idx   <= 4'd0;
            r_shift     <= 15'd0;
            r_gap_half  <= 1'b0;
            r_sclk      <= 1'b1;
            r_sync_n    <= 1'b1;
            r_sdata     <= 1'b0;
            r_din_ready <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= r_state_next;
            r_phase     <= r_phase_next;
            r_bit_idx   <= r_bit_idx_next;
            r_shift     <= r_shift_next;
            r_gap_half  <= r_gap_half_next;
            r_sclk      <= r_sclk_next;
            r_sync_n    <= r_sync_n_next;
            r_sdata     <= r_sdata_next;
            r_din_ready <= r_din_ready_next;
            r_done      <= r_done_next;
        end
    end

    always_comb begin
        r_state_next     = r_state;
        r_phase_next     = r_phase;
        r_bit_idx_next   = r_bit_idx;
        r_shift_next     = r_shift;
        r_gap_half_next  = r_gap_half;
        r_sclk_next      = r_sclk;
        r_sync_n_next    = r_sync_n;
        r_sdata_next     = r_sdata;
        r_din_ready_next = r_din_ready;
        r_done_next      = 1'b0;

        case (r_state)
            IDLE: begin
                r_din_ready_next = 1'b1;
                r_sclk_next      = 1'b1;
                r_sync_n_next    = 1'b1;
                if (w_accept) begin
                    r_state_next     = SHIFT;
                    r_bit_idx_next   = 4'd15;
                    r_phase_next     = 8'd0;
                    r_sync_n_next    = 1'b0;
                    r_sdata_next     = w_frame[15];
                    r_shift_next     = w_frame[14:0];
                    r_din_ready_next = 1'b0;
                end
            end
            SHIFT: begin
                if (w_phase_end) begin
                    r_phase_next = 8'd0;
                    // sclk doubles as the half-bit flag while shifting
                    if (r_sclk) begin
                        r_sclk_next = 1'b0;
                    end else if (r_bit_idx != 4'd0) begin
                        r_bit_idx_next = r_bit_idx - 4'd1;
                        r_sdata_next   = r_shift[14];
                        r_shift_next   = {r_shift[13:0], 1'b0};
                        r_sclk_next    = 1'b1;
                    end else begin
                        r_state_next    = GAP;
                        r_sync_n_next   = 1'b1;
                        r_sclk_next     = 1'b1;
                        r_sdata_next    = 1'b0;
                        r_gap_half_next = 1'b0;
                    end
                end else begin
                    r_phase_next = r_phase + 8'd1;
                end
            end
            GAP: begin
                if (w_phase_end) begin
                    r_phase_next = 8'd0;
                    if (!r_gap_half) begin
                        r_gap_half_next = 1'b1;
                    end else begin
                        r_gap_half_next  = 1'b0;
                        r_state_next     = IDLE;
                        r_done_next      = 1'b1;
                        r_din_ready_next = 1'b1;
                    end
                end else begin
                    r_phase_next = r_phase + 8'd1;
                end
            end
            default: begin
                r_state_next = IDLE;
            end
        endcase
    end

    assign bus.din_ready = r_din_ready;
    assign bus.sclk      = r_sclk;
    assign bus.sync_n    = r_sync_n;
    assign bus.sdata     = r_sdata;
    assign bus.done      = r_done;
endmodule
